// File: rtl/async_fifo_rd_stream.sv
// rtl/async_fifo_rd_stream.sv - FIFO read drain: pop credit, 2-entry skid buffer, valid/ready out
module async_fifo_rd_stream #(
    parameter int DWIDTH   = 8,
    parameter int CNTWIDTH = 16
) (
    input  logic                rclk,
    input  logic                reset_L,
    input  logic                empty,
    input  logic [DWIDTH-1:0]   rdata,
    output logic                pop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DWIDTH-1:0]   out_data,
    output logic [CNTWIDTH-1:0] xfer_cnt
);

    // Encoding doubles as the number of buffered words.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } occ_t;

    occ_t              occ;
    occ_t              occ_next;
    logic              inflight;
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] tail;
    logic [DWIDTH-1:0] head_next;
    logic [DWIDTH-1:0] tail_next;
    logic              fire;
    logic [1:0]        occ_words;
    logic [2:0]        level;

    assign out_valid = (occ != S0);
    assign out_data  = head;
    assign fire      = out_valid & out_ready;

    // Committed words (buffered plus in flight) must stay within the two slots.
    assign occ_words = occ;
    assign level     = {1'b0, occ_words} + {2'b00, inflight};
    assign pop       = reset_L & ~empty & (level < (3'd2 + {2'b00, fire}));

    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        case (occ)
            S0: begin
                if (inflight) begin
                    occ_next  = S1;
                    head_next = rdata;
                end
            end
            S1: begin
                case ({inflight, fire})
                    2'b11: head_next = rdata;
                    2'b10: begin
                        occ_next  = S2;
                        tail_next = rdata;
                    end
                    2'b01: occ_next = S0;
                    default: ;
                endcase
            end
            S2: begin
                if (fire) begin
                    head_next = tail;
                    if (inflight) begin
                        tail_next = rdata;
                    end else begin
                        occ_next = S1;
                    end
                end
            end
            default: occ_next = S0;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!reset_L) begin
            occ      <= S0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            xfer_cnt <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= pop;
            head     <= head_next;
            tail     <= tail_next;
            xfer_cnt <= xfer_cnt + CNTWIDTH'(fire);
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// tb/tb_async_fifo_rd_stream.sv - scoreboard bench for async_fifo_rd_stream
module tb_async_fifo_rd_stream;

    logic        rclk      = 1'b0;
    logic        reset_L   = 1'b0;
    logic        empty     = 1'b1;
    logic [7:0]  rdata     = 8'h00;
    logic        out_ready = 1'b0;
    logic        pop;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] xfer_cnt;
    logic        pop4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  xfer_cnt4;

    async_fifo_rd_stream #(.DWIDTH(8), .CNTWIDTH(16)) dut (
        .rclk(rclk), .reset_L(reset_L), .empty(empty), .rdata(rdata), .pop(pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
    );

    async_fifo_rd_stream #(.DWIDTH(8), .CNTWIDTH(4)) dut4 (
        .rclk(rclk), .reset_L(reset_L), .empty(empty), .rdata(rdata), .pop(pop4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .xfer_cnt(xfer_cnt4)
    );

    always #5 rclk = ~rclk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         delivered = 0;
    int         outstanding = 0;
    int         first_pop = -1;
    int         first_vld = -1;
    int         first_fire = -1;
    int         last_fire = -1;
    int         pops;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pend = 8'h00;
    bit         pend_v = 1'b0;
    bit         last_pop = 1'b0;
    logic [7:0] last_word = 8'h00;
    bit         saw_wrap = 1'b0;
    logic [3:0] prev4 = 4'd0;
    bit         stall_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit         f;
    bit         f4;
    logic [7:0] w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // emode 0: empty from model, 1: model plus random stale empty, 2: forced low
    task automatic step(input int emode, input bit rdy, input bit rstn);
        @(negedge rclk);
        reset_L = rstn;
        if (pend_v) rdata = pend;
        case (emode)
            0:       empty = (fifo_q.size() == 0);
            1:       empty = (fifo_q.size() == 0) || ($urandom_range(0, 9) < 3);
            default: empty = 1'b0;
        endcase
        out_ready = rdy;
        #1;
        cyc++;
        chk("pop_while_empty", {31'b0, pop & empty}, 0);
        chk("pop4_while_empty", {31'b0, pop4 & empty}, 0);
        if (!rstn) chk("pop_in_reset", {31'b0, pop}, 0);
        last_pop = pop;
        pend_v = 1'b0;
        if (pop && !empty && fifo_q.size() > 0) begin
            pend = fifo_q.pop_front();
            pend_v = 1'b1;
            if (first_pop < 0) first_pop = cyc;
        end
        if (out_valid === 1'b1 && first_vld < 0) first_vld = cyc;
        chk("xfer_cnt", {16'b0, xfer_cnt}, delivered % 65536);
        chk("xfer_cnt4", {28'b0, xfer_cnt4}, delivered % 16);
        if (prev4 == 4'd15 && xfer_cnt4 == 4'd0) saw_wrap = 1'b1;
        prev4 = xfer_cnt4;
        if (!rstn) outstanding = 0;
        else outstanding = outstanding + int'(pop) - int'(out_valid & out_ready);
        chk("occ_plus_inflight_le2", {31'b0, outstanding <= 2}, 1);
    endtask

    task automatic clear_track();
        first_pop = -1;
        first_vld = -1;
        first_fire = -1;
        last_fire = -1;
        saw_wrap = 1'b0;
        prev4 = 4'd0;
    endtask

    task automatic do_reset();
        step(2, 1'b0, 1'b0);
        fifo_q.delete();
        exp_q.delete();
        pend_v = 1'b0;
        delivered = 0;
        step(2, 1'b0, 1'b0);
        clear_track();
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(8'((base + i) % 256));
            exp_q.push_back(8'((base + i) % 256));
        end
    endtask

    task automatic run_until(input string name, input int target, input int maxc,
                             input int emode, input bit rdy_rand);
        for (int i = 0; i < maxc && delivered < target; i++)
            step(emode, rdy_rand ? ($urandom_range(0, 9) < 6) : 1'b1, 1'b1);
        chk({name, "_delivered"}, delivered, target);
    endtask

    // Monitor: pops the expected word whenever either instance completes a handshake.
    always @(negedge rclk) begin
        #2;
        f  = reset_L && out_valid && out_ready;
        f4 = reset_L && out_valid4 && out_ready;
        if (stall_prev) chk("hold_out_data", {24'b0, out_data}, {24'b0, hold_data});
        stall_prev = reset_L && out_valid && !out_ready;
        hold_data  = out_data;
        if (f || f4) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got 0x%0h expected none (cycle %0d)", out_data, cyc);
            end else begin
                w = exp_q.pop_front();
                chk("data", {24'b0, out_data}, {24'b0, w});
                chk("data_cnt4", {24'b0, out_data4}, {24'b0, w});
                chk("fire", {31'b0, f}, 1);
                chk("fire_cnt4", {31'b0, f4}, 1);
                delivered++;
                last_word = out_data;
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
            end
        end
    end

    initial begin
        repeat (5) begin
            step(2, 1'b1, 1'b0);
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_out_data", {24'b0, out_data}, 0);
            chk("rst_xfer_cnt", {16'b0, xfer_cnt}, 0);
        end

        do_reset();
        load(16, 1);
        run_until("stream", 16, 80, 0, 1'b0);
        repeat (3) step(0, 1'b1, 1'b1);
        chk("stream_pop_idle", {31'b0, pop}, 0);
        chk("stream_latency", first_vld - first_pop, 2);
        chk("stream_span", last_fire - first_fire, 15);
        chk("stream_cnt", {16'b0, xfer_cnt}, 16);

        do_reset();
        load(8, 'hA0);
        pops = 0;
        repeat (10) begin
            step(0, 1'b0, 1'b1);
            pops += int'(last_pop);
        end
        chk("bp_pops", pops, 2);
        chk("bp_pop_now", {31'b0, pop}, 0);
        chk("bp_valid", {31'b0, out_valid}, 1);
        chk("bp_head", {24'b0, out_data}, 'hA0);
        run_until("bp", 8, 40, 0, 1'b0);
        chk("bp_span", last_fire - first_fire, 7);
        step(0, 1'b1, 1'b1);
        chk("bp_cnt", {16'b0, xfer_cnt}, 8);

        do_reset();
        load(1000, 0);
        run_until("random", 1000, 20000, 1, 1'b1);
        chk("random_left", exp_q.size(), 0);

        do_reset();
        load(18, 'h40);
        run_until("wrap", 18, 80, 0, 1'b0);
        step(0, 1'b1, 1'b1);
        chk("wrap_seen", {31'b0, saw_wrap}, 1);
        chk("wrap_cnt4", {28'b0, xfer_cnt4}, 2);
        chk("wrap_cnt16", {16'b0, xfer_cnt}, 18);

        do_reset();
        load(6, 'h30);
        run_until("pre_reset", 2, 40, 0, 1'b0);
        repeat (5) step(0, 1'b0, 1'b1);
        chk("mid_full", outstanding, 2);
        chk("mid_valid", {31'b0, out_valid}, 1);
        step(0, 1'b0, 1'b0);
        fifo_q.delete();
        exp_q.delete();
        pend_v = 1'b0;
        delivered = 0;
        step(0, 1'b0, 1'b1);
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_cnt", {16'b0, xfer_cnt}, 0);
        clear_track();
        load(1, 'h55);
        run_until("refill", 1, 20, 0, 1'b0);
        chk("refill_word", {24'b0, last_word}, 'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
